alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: FIFO-fed ALU command sequencer with settle-timed capture; `define ALU_SEQ_ERRCNT_EN adds err_count
module alu_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE = 2
) (
`ifdef ALU_SEQ_ERRCNT_EN
  output logic [7:0]  err_count,
`endif
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [15:0] alu_input1,
  output logic [15:0] alu_input2,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_error,
  output logic        busy
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d;
  logic [3:0] settle_q, settle_d;
  logic [15:0] in1_q, in1_d, in2_q, in2_d;
  logic [3:0] op_q, op_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [1:0] rsp_error_q, rsp_error_d;
  logic [35:0] mem_q [FIFO_DEPTH];
  logic [35:0] head;
  logic push, pop, hs;
  always_comb begin
    push = cmd_valid & ready_q;
    pop = (state_q == IDLE) & (cnt_q != '0);
    hs = (state_q == RESP) & rsp_valid_q & rsp_ready;
    head = mem_q[rd_q];
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ready_d = cnt_d != CW'(FIFO_DEPTH);
    state_d = state_q;
    settle_d = settle_q;
    in1_d = in1_q;
    in2_d = in2_q;
    op_d = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d = rsp_error_q;
    if (pop) begin
      state_d = WAIT;
      settle_d = 4'(SETTLE);
      in1_d = head[15:0];
      in2_d = head[31:16];
      op_d = head[35:32];
    end
    if (state_q == WAIT) begin
      settle_d = settle_q - 4'd1;
      if (settle_q == 4'd1) begin
        state_d = RESP;
        rsp_valid_d = 1'b1;
        rsp_result_d = alu_result;
        rsp_error_d = alu_error;
      end
    end
    if (hs) begin
      state_d = IDLE;
      rsp_valid_d = 1'b0;
      op_d = 4'd0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
      settle_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      op_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      settle_q <= settle_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      op_q <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q <= rsp_error_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {cmd_op, cmd_b, cmd_a};
  end
`ifdef ALU_SEQ_ERRCNT_EN
  logic [7:0] err_q, err_d;
  always_comb err_d = (hs && rsp_error_q != 2'b00 && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else err_q <= err_d;
  end
  assign err_count = err_q;
`endif
  assign cmd_ready = ready_q;
  assign alu_input1 = in1_q;
  assign alu_input2 = in2_q;
  assign alu_opcode = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error = rsp_error_q;
  assign busy = (state_q != IDLE) | (cnt_q != '0);
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random stimulus against an in-order command/response scoreboard
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [15:0] cmd_a, cmd_b, alu_input1, alu_input2;
  logic [3:0] cmd_op, alu_opcode;
  logic [31:0] alu_result = '0;
  logic [31:0] rsp_result;
  logic [1:0] alu_error = '0;
  logic [1:0] rsp_error;
`ifdef ALU_SEQ_ERRCNT_EN
  logic [7:0] err_count;
`endif
  typedef struct packed {logic [15:0] a; logic [15:0] b; logic [3:0] op;} cmd_t;
  cmd_t exp_q[$];
  logic [33:0] rsp_log[$];
  int n_acc = 0;
  int n_pass = 0;
  int n_chk = 0;
  alu_sequencer dut (
`ifdef ALU_SEQ_ERRCNT_EN
    .err_count(err_count),
`endif
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [33:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    case (op)
      4'd1: return {2'b00, 32'(a) + 32'(b)};
      4'd2: return {(a < b) ? 2'b01 : 2'b00, 32'(a) - 32'(b)};
      4'd3: return {2'b00, 32'(a) * 32'(b)};
      4'd4: return (b == 16'd0) ? {2'b10, 32'd0} : {2'b00, 32'(a / b)};
      4'd5: return (b == 16'd0) ? {2'b10, 32'd0} : {2'b00, 32'(a % b)};
      default: return 34'd0;
    endcase
  endfunction
  always @(posedge clk) {alu_error, alu_result} <= alu_f(alu_input1, alu_input2, alu_opcode);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q.delete();
    else begin
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back('{cmd_a, cmd_b, cmd_op});
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        cmd_t c;
        rsp_log.push_back({rsp_error, rsp_result});
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          c = exp_q.pop_front();
          chk("rsp", {rsp_error, rsp_result}, alu_f(c.a, c.b, c.op));
        end
      end
    end
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    int t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("send_timeout", 0, 1);
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", t < 1000, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int base;
    int acc0;
    logic [33:0] hold;
    logic [31:0] exp5 [5];
    exp5 = '{32'd11, 32'd9, 32'd36, 32'd3, 32'd4};
    cmd_valid = 0;
    cmd_a = 0;
    cmd_b = 0;
    cmd_op = 0;
    rsp_ready = 0;
    rst = 0;
    #1 rst = 1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_alu_in", {alu_input1, alu_input2}, 0);
    chk("rst_alu_op", alu_opcode, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    rsp_ready = 1;
    base = rsp_log.size();
    send(3, 1, 1);
    chk("busy_after_accept", busy, 1);
    @(negedge clk);
    chk("lat_n1", rsp_valid, 0);
    @(negedge clk);
    chk("lat_n2", rsp_valid, 0);
    @(negedge clk);
    chk("lat_n3", rsp_valid, 1);
    chk("add_result", rsp_result, 4);
    chk("add_error", rsp_error, 0);
    chk("issued_a", alu_input1, 3);
    chk("issued_op", alu_opcode, 1);
    drain();
    chk("add_count", rsp_log.size() - base, 1);
    chk("op_cleared", alu_opcode, 0);
    base = rsp_log.size();
    send(3, 1, 2);
    send(3, 1, 3);
    send(3, 1, 5);
    drain();
    chk("seq_count", rsp_log.size() - base, 3);
    chk("seq_sub", rsp_log[base], {2'b00, 32'd2});
    chk("seq_mul", rsp_log[base + 1], {2'b00, 32'd3});
    chk("seq_mod", rsp_log[base + 2], {2'b00, 32'd0});
`ifdef ALU_SEQ_ERRCNT_EN
    chk("errcnt_before", err_count, 0);
`endif
    base = rsp_log.size();
    send(7, 0, 4);
    drain();
    chk("div0_error", rsp_log[base][33:32], 2'b10);
`ifdef ALU_SEQ_ERRCNT_EN
    chk("errcnt_after", err_count, 1);
`endif
    rsp_ready = 0;
    base = rsp_log.size();
    for (int i = 0; i < 5; i++) send(16'(10 + i), 16'(i + 1), 4'(i % 5 + 1));
    chk("full_ready_low", cmd_ready, 0);
    chk("full_rsp_valid", rsp_valid, 1);
    hold = {rsp_error, rsp_result};
    repeat (5) @(negedge clk);
    chk("hold_valid", rsp_valid, 1);
    chk("hold_stable", {rsp_error, rsp_result}, hold);
    chk("hold_value", hold, {2'b00, 32'd11});
    rsp_ready = 1;
    drain();
    chk("full_count", rsp_log.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("full_order", rsp_log[base + i], {2'b00, exp5[i]});
    send(1, 2, 1);
    send(3, 4, 1);
    send(5, 6, 1);
    chk("mid_busy", busy, 1);
    chk("mid_no_rsp", rsp_valid, 0);
    base = rsp_log.size();
    rst = 1;
    #1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_op", alu_opcode, 0);
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_rsp", rsp_log.size() - base, 0);
    chk("rst_mid_idle", busy, 0);
    acc0 = n_acc;
    base = rsp_log.size();
    repeat (400) begin
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_a = 16'($urandom);
      cmd_b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 300));
      cmd_op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 5));
      rsp_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    drain();
    chk("rand_count", rsp_log.size() - base, n_acc - acc0);
    chk("rand_nonempty", (n_acc - acc0) > 20, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
